cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt sink at the M stage of the 5-stage MIPS pipeline.
- Consumes the exception code that the pipeline exception-code registers carry down to M, plus the six hardware interrupt lines.
- Decides whether to take an exception or interrupt, and records SR/Cause/EPC.
- Drives IntReq (pipeline flush and jump to the handler at 0x4180) and EPC (the eret target).
- Serves mfc0/mtc0 reads and writes.

Parameters:
- PRID, 32'h2018_0001, read-only value returned for register 15 (PRId).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- A  in  5  CP0 register number for mfc0/mtc0 (12=SR, 13=Cause, 14=EPC, 15=PRId)
- DIn  in  32  mtc0 write data
- We  in  1  mtc0 write enable
- PC  in  32  PC of the instruction in M
- BDIn  in  1  M instruction sits in a branch delay slot
- ExcCodeIn  in  5  exception code from the M-stage exception-code register; 0 = no exception
- HWInt  in  6  hardware interrupt lines, level-sensitive
- EXLClr  in  1  eret in M: clear EXL
- IntReq  out  1  take exception/interrupt this cycle (combinational)
- EPC  out  32  current EPC register value
- DOut  out  32  mfc0 read data (combinational)

Behaviour:
- SR (reg 12) fields:
  - IM = SR[15:10]
  - EXL = SR[1]
  - IE = SR[0]
  - all other bits read 0
- Cause (reg 13) fields:
  - BD = Cause[31]
  - IP = Cause[15:10]
  - ExcCode = Cause[6:2]
  - all other bits read 0
- Reset (synchronous, priority over everything):
  - SR=0, Cause=0, EPC=0.
  - IntReq is forced 0 while reset is high.
- Decode (combinational):
  - IntPend = IE & ~EXL & |(HWInt & IM)
  - ExcPend = ~EXL & (ExcCodeIn != 0)
  - IntReq = ~reset & (IntPend | ExcPend)
  - Interrupt has priority over a synchronous exception.
- On a posedge with IntReq=1, all updates happen in the same edge:
  - EXL <= 1.
  - Cause.ExcCode <= IntPend ? 0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= (BDIn ? PC-4 : PC) with bits [1:0] forced to 0.
  - An mtc0 in the same cycle is ignored; the faulting instruction does not commit.
- Cause.IP <= HWInt every non-reset cycle, regardless of IntReq, EXL, or We.
- mtc0 (We=1, IntReq=0):
  - A=12 writes IM, EXL, and IE only.
  - A=14 writes the full 32 bits.
  - A=13, A=15, and other numbers: write ignored.
- EXLClr=1 and IntReq=0: EXL <= 0 at the edge.
  - If the same cycle also has mtc0 to SR, EXLClr wins for EXL; IM and IE still take DIn.
- EXLClr with IntReq=1: IntReq wins and EXL stays 1. This is unreachable in practice, since IntReq needs EXL=0.
- While EXL=1, no new exception or interrupt is taken; pending HWInt is still visible in Cause.IP.
- Read (DOut): mux on A.
  - 12 → SR
  - 13 → Cause
  - 14 → EPC
  - 15 → PRID
  - other → 0
  - Read reflects register state before the current edge; there is no bypass of a same-cycle write.
- Latency: IntReq is 0-cycle combinational. Register effects are visible on DOut and EPC one cycle after the edge.

Test Plan:
- Reset then idle → SR=Cause=EPC=0; DOut(A=15)=32'h2018_0001; IntReq=0 even when ExcCodeIn=5'd4 during reset.
- ExcCodeIn=5'd10 (RI), PC=0x3010, BDIn=0 → IntReq=1 same cycle; next cycle EPC=0x3010, Cause.ExcCode=10, EXL=1; repeat ExcCodeIn=10 → IntReq=0.
- ExcCodeIn=5'd12 (Ov), PC=0x3020, BDIn=1 → EPC=0x301C, Cause=0x8000_0030.
- mtc0 SR=0x0000_0401, then HWInt=6'b000001 → IntReq=1; Cause.ExcCode=0, IP=000001; HWInt=6'b000010 with IM=000001 → IntReq=0, IP=000010.
- HWInt enabled and ExcCodeIn=4 in the same cycle → ExcCode recorded as 0 (interrupt priority); then EXLClr=1 → EXL=0, and IntReq reasserts next cycle while HWInt is still high.
- mtc0 to A=13 with 0xFFFF_FFFF → Cause unchanged; mtc0 A=14 0x0000_3000 while IntReq=1 → write ignored, EPC takes the PC value.

Source files
------------

// File: rtl/cp0_exc_unit_if.sv
// Pipeline-to-CP0 bus: mfc0/mtc0 access, M-stage exception info and interrupt lines.
// The pipeline drives the master side; CP0 answers with IntReq, EPC and DOut.
interface cp0_exc_unit_if;
  logic [4:0]  A;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A, DIn, We, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  A, DIn, We, PC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt sink at the M stage: decides when to trap,
// keeps SR/Cause/EPC and serves mfc0/mtc0.
module cp0_exc_unit #(
  parameter logic [31:0] PRID = 32'h2018_0001
) (
  input logic            clk,
  input logic            reset,
  cp0_exc_unit_if.slave  bus
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic        int_req;
  logic [31:0] pc_adj;
  logic [31:0] epc_exc;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;

  assign int_pend = ie_q & ~exl_q & (|(bus.HWInt & im_q));
  assign exc_pend = ~exl_q & (bus.ExcCodeIn != 5'd0);
  assign int_req  = ~reset & (int_pend | exc_pend);

  // A fault in a delay slot restarts at the branch, one word back.
  assign pc_adj  = bus.BDIn ? (bus.PC - 32'd4) : bus.PC;
  assign epc_exc = pc_adj & 32'hFFFF_FFFC;

  assign sr_rd    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_rd = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    ip_d      = bus.HWInt;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    if (int_req) begin
      // The trapping instruction never commits, so its mtc0 is dropped.
      exl_d     = 1'b1;
      exccode_d = int_pend ? 5'd0 : bus.ExcCodeIn;
      bd_d      = bus.BDIn;
      epc_d     = epc_exc;
    end else begin
      if (bus.We && bus.A == REG_SR) begin
        im_d  = bus.DIn[15:10];
        exl_d = bus.DIn[1];
        ie_d  = bus.DIn[0];
      end
      if (bus.We && bus.A == REG_EPC) begin
        epc_d = bus.DIn;
      end
      if (bus.EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= 6'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  always_comb begin
    case (bus.A)
      REG_SR:    bus.DOut = sr_rd;
      REG_CAUSE: bus.DOut = cause_rd;
      REG_EPC:   bus.DOut = epc_q;
      REG_PRID:  bus.DOut = PRID;
      default:   bus.DOut = 32'd0;
    endcase
  end

  assign bus.IntReq = int_req;
  assign bus.EPC    = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed, table-driven check of cp0_exc_unit: each row is one clock cycle of
// inputs plus the IntReq/DOut/EPC expected before that cycle's edge.
module tb_cp0_exc_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  cp0_exc_unit_if bus ();

  cp0_exc_unit #(.PRID(32'h2018_0001)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  a;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        exlclr;
    logic        e_int;
    logic [31:0] e_dout;
    logic [31:0] e_epc;
  } vec_t;

  localparam int NV = 29;
  localparam logic [31:0] P = 32'h0000_3000;
  vec_t vt [NV];

  function automatic vec_t v(logic rst, logic [4:0] a, logic [31:0] din, logic we,
                             logic [31:0] pc, logic bd, logic [4:0] exc, logic [5:0] hw,
                             logic exlclr, logic e_int, logic [31:0] e_dout,
                             logic [31:0] e_epc);
    vec_t r;
    r.rst = rst; r.a = a; r.din = din; r.we = we; r.pc = pc; r.bd = bd;
    r.exc = exc; r.hw = hw; r.exlclr = exlclr;
    r.e_int = e_int; r.e_dout = e_dout; r.e_epc = e_epc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    reset         = x.rst;
    bus.A         = x.a;
    bus.DIn       = x.din;
    bus.We        = x.we;
    bus.PC        = x.pc;
    bus.BDIn      = x.bd;
    bus.ExcCodeIn = x.exc;
    bus.HWInt     = x.hw;
    bus.EXLClr    = x.exlclr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    total = 0;
    bad   = 0;

    //          rst a   din            we pc          bd exc hw     clr  int dout           epc
    vt[0]  = v(1, 15, 32'h0,          0, P,          0, 4,  6'b0,  0,   0, 32'h2018_0001, 32'h0);
    vt[1]  = v(0, 12, 32'h0,          0, P,          0, 0,  6'b0,  0,   0, 32'h0,         32'h0);
    vt[2]  = v(0, 13, 32'h0,          0, P,          0, 0,  6'b0,  0,   0, 32'h0,         32'h0);
    vt[3]  = v(0, 14, 32'h0,          0, P,          0, 0,  6'b0,  0,   0, 32'h0,         32'h0);
    vt[4]  = v(0, 13, 32'h0,          0, 32'h3010,   0, 10, 6'b0,  0,   1, 32'h0,         32'h0);
    vt[5]  = v(0, 13, 32'h0,          0, 32'h3010,   0, 10, 6'b0,  0,   0, 32'h28,        32'h3010);
    vt[6]  = v(0, 12, 32'h0,          0, P,          0, 0,  6'b0,  0,   0, 32'h2,         32'h3010);
    vt[7]  = v(0, 12, 32'h0,          0, P,          0, 0,  6'b0,  1,   0, 32'h2,         32'h3010);
    vt[8]  = v(0, 12, 32'h0,          0, 32'h3020,   1, 12, 6'b0,  0,   1, 32'h0,         32'h3010);
    vt[9]  = v(0, 13, 32'h0,          0, P,          0, 0,  6'b0,  0,   0, 32'h8000_0030, 32'h301C);
    vt[10] = v(0, 12, 32'h401,        1, P,          0, 0,  6'b0,  0,   0, 32'h2,         32'h301C);
    vt[11] = v(0, 12, 32'h0,          0, 32'h3040,   0, 0,  6'b1,  0,   1, 32'h401,       32'h301C);
    vt[12] = v(0, 13, 32'h0,          0, P,          0, 0,  6'b10, 0,   0, 32'h400,       32'h3040);
    vt[13] = v(0, 13, 32'h0,          0, P,          0, 0,  6'b0,  1,   0, 32'h800,       32'h3040);
    vt[14] = v(0, 12, 32'h0,          0, P,          0, 0,  6'b10, 0,   0, 32'h401,       32'h3040);
    vt[15] = v(0, 13, 32'h0,          0, P,          0, 0,  6'b0,  0,   0, 32'h800,       32'h3040);
    vt[16] = v(0, 13, 32'h0,          0, 32'h3050,   0, 4,  6'b1,  0,   1, 32'h0,         32'h3040);
    vt[17] = v(0, 13, 32'h0,          0, P,          0, 0,  6'b1,  1,   0, 32'h400,       32'h3050);
    vt[18] = v(0, 12, 32'h0,          0, 32'h3060,   0, 0,  6'b1,  0,   1, 32'h401,       32'h3050);
    vt[19] = v(0, 13, 32'hFFFF_FFFF,  1, P,          0, 0,  6'b0,  0,   0, 32'h400,       32'h3060);
    vt[20] = v(0, 13, 32'h0,          0, P,          0, 0,  6'b0,  1,   0, 32'h0,         32'h3060);
    vt[21] = v(0, 14, 32'h3000,       1, 32'h3070,   0, 10, 6'b0,  0,   1, 32'h3060,      32'h3060);
    vt[22] = v(0, 12, 32'h403,        1, P,          0, 0,  6'b0,  1,   0, 32'h403,       32'h3070);
    vt[23] = v(0, 12, 32'h0,          0, P,          0, 0,  6'b0,  0,   0, 32'h401,       32'h3070);
    vt[24] = v(0, 14, 32'h1234_5678,  1, P,          0, 0,  6'b0,  0,   0, 32'h3070,      32'h3070);
    vt[25] = v(0, 14, 32'h0,          0, P,          0, 0,  6'b0,  0,   0, 32'h1234_5678, 32'h1234_5678);
    vt[26] = v(0, 7,  32'h0,          0, P,          0, 0,  6'b0,  0,   0, 32'h0,         32'h1234_5678);
    vt[27] = v(1, 14, 32'h0,          0, P,          0, 4,  6'b1,  0,   0, 32'h1234_5678, 32'h1234_5678);
    vt[28] = v(0, 14, 32'h0,          0, P,          0, 0,  6'b0,  0,   0, 32'h0,         32'h0);

    idle = v(1, 0, 32'h0, 0, P, 0, 0, 6'b0, 0, 0, 32'h0, 32'h0);
    drive(idle);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #2;
      $display("vec %0d: A=%0d IntReq=%b DOut=%h EPC=%h", i, vt[i].a, bus.IntReq, bus.DOut, bus.EPC);
      check($sformatf("vec%0d_intreq", i), {31'b0, bus.IntReq}, {31'b0, vt[i].e_int});
      check($sformatf("vec%0d_dout", i), bus.DOut, vt[i].e_dout);
      check($sformatf("vec%0d_epc", i), bus.EPC, vt[i].e_epc);
    end

    // Exception in a delay slot with an mtc0 SR in the same cycle: write is dropped.
    @(negedge clk);
    drive(v(0, 12, 32'h0000_FC01, 1, 32'h3080, 1, 8, 6'b0, 0, 0, 32'h0, 32'h0));
    #2;
    $display("seq trap+mtc0: IntReq=%b", bus.IntReq);
    check("seq_trap_intreq", {31'b0, bus.IntReq}, 32'd1);
    @(negedge clk);
    drive(v(0, 12, 32'h0, 0, P, 0, 0, 6'b0, 0, 0, 32'h0, 32'h0));
    #2;
    $display("seq sr read: DOut=%h", bus.DOut);
    check("seq_sr_after_trap", bus.DOut, 32'h0000_0002);
    check("seq_intreq_blocked", {31'b0, bus.IntReq}, 32'd0);
    @(negedge clk);
    drive(v(0, 13, 32'h0, 0, P, 0, 0, 6'b0, 0, 0, 32'h0, 32'h0));
    #2;
    $display("seq cause read: DOut=%h EPC=%h", bus.DOut, bus.EPC);
    check("seq_cause_bd", bus.DOut, 32'h8000_0020);
    check("seq_epc_bd", bus.EPC, 32'h0000_307C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
